// File: rtl/fb_pixel_writer.sv
// Frame-buffer write engine: queued rasterizer pixels or a whole-frame clear become Avalon-MM word writes.
// Pixel into an empty idle FIFO reaches master_write next cycle; pix_ready drops when full or a clear is pending/active.
module fb_pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] frame_buffer_ptr,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [23:0] pix_color,
  input  logic        clear_start,
  input  logic [23:0] clear_color,
  output logic        busy,
  output logic        clear_done,
  output logic [7:0]  oob_count,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic        master_read,
  output logic [3:0]  master_byteenable,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TOTAL = H_RES * V_RES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] color;
  } pix_t;

  pix_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic          clear_pending, ready_en;
  logic [CW-1:0] clr_cnt;
  logic [25:0]   clr_base;
  logic [23:0]   clr_color;

  pix_t        in_pix, nxt_pix;
  logic        accept, in_range, push, done, pop, have_next, clr_req;
  logic [25:0] clr_base_eff;
  logic [23:0] clr_color_eff;

  function automatic logic [25:0] pix_addr(input logic [25:0] base, input logic [9:0] x,
                                           input logic [8:0] y);
    logic [25:0] lin;
    lin = 26'(32'(y) * 32'(H_RES) + 32'(x));
    return base + (lin << 2);
  endfunction

  assign in_pix    = '{x: pix_x, y: pix_y, color: pix_color};
  assign pix_ready = ready_en && (count != (AW+1)'(FIFO_DEPTH)) && (state != CLEAR) && !clear_pending;
  assign accept    = pix_valid && pix_ready;
  assign in_range  = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
  assign push      = accept && in_range;
  assign done      = master_write && !master_waitrequest;
  assign pop       = done && (state == WRITE);
  assign clr_req   = clear_start && (state != CLEAR) && !clear_pending;

  assign clr_base_eff  = clear_pending ? clr_base  : frame_buffer_ptr;
  assign clr_color_eff = clear_pending ? clr_color : clear_color;

  assign busy              = (count != '0) || master_write || (state == CLEAR) || clear_pending;
  assign master_read       = 1'b0;
  assign master_byteenable = 4'b1111;

  // The head entry stays queued while its write is in flight, so the next word to
  // launch is the entry behind it, or the incoming pixel when nothing else is queued.
  always_comb begin
    nxt_pix   = in_pix;
    have_next = push;
    if (state == WRITE) begin
      if (count > (AW+1)'(1)) begin
        nxt_pix   = fifo_mem[rd_ptr + AW'(1)];
        have_next = 1'b1;
      end
    end else if (count != '0) begin
      nxt_pix   = fifo_mem[rd_ptr];
      have_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_pix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      state            <= IDLE;
      clear_pending    <= 1'b0;
      ready_en         <= 1'b0;
      clr_cnt          <= '0;
      clr_base         <= '0;
      clr_color        <= '0;
      oob_count        <= '0;
      clear_done       <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
    end else begin
      ready_en   <= 1'b1;
      clear_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (accept && !in_range && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
      if (clr_req) begin
        clear_pending <= 1'b1;
        clr_base      <= frame_buffer_ptr;
        clr_color     <= clear_color;
      end
      case (state)
        IDLE: begin
          if (have_next) begin
            master_write     <= 1'b1;
            master_address   <= pix_addr(frame_buffer_ptr, nxt_pix.x, nxt_pix.y);
            master_writedata <= {8'h00, nxt_pix.color};
            state            <= WRITE;
          end else if (clr_req || clear_pending) begin
            master_write     <= 1'b1;
            master_address   <= clr_base_eff;
            master_writedata <= {8'h00, clr_color_eff};
            clr_cnt          <= '0;
            clear_pending    <= 1'b0;
            state            <= CLEAR;
          end
        end
        WRITE: begin
          if (done) begin
            if (have_next) begin
              master_address   <= pix_addr(frame_buffer_ptr, nxt_pix.x, nxt_pix.y);
              master_writedata <= {8'h00, nxt_pix.color};
            end else if (clr_req || clear_pending) begin
              master_address   <= clr_base_eff;
              master_writedata <= {8'h00, clr_color_eff};
              clr_cnt          <= '0;
              clear_pending    <= 1'b0;
              state            <= CLEAR;
            end else begin
              master_write <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (done) begin
            if (clr_cnt == CW'(TOTAL - 1)) begin
              master_write <= 1'b0;
              clear_done   <= 1'b1;
              state        <= IDLE;
            end else begin
              clr_cnt        <= clr_cnt + CW'(1);
              master_address <= master_address + 26'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
